accumulator_bank_array: RTL

- Double-buffered array of accumulating banks, the successor to the plain write/read accumulator banks.
- Each bank performs signed read-modify-write accumulation (`entry += data`) into the front buffer. Adds are packed-lane, with 1, 2 or 4 lanes per word.
- On swap, the finished buffer becomes the back buffer and is streamed out through a valid/ready drain port. Each entry is cleared as it is drained.
- Sits between the multiplier/scatter crossbar (accumulate inputs) and the output writeback/ReLU stage (drain).

---
 rtl/accumulator_bank_array.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/accumulator_bank_array.sv
// accumulator_bank_array: double-buffered packed-lane accumulator banks with a valid/ready drain port.
// Define ACC_SATURATE_EN to clamp lane sums instead of wrapping.
module accumulator_bank_array #(
    parameter int BANK_COUNT = 4,
    parameter int DEPTH      = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [1:0]                                    mode,
    input  logic [BANK_COUNT-1:0]                         acc_valid,
    input  logic [BANK_COUNT*$clog2(DEPTH)-1:0]           acc_addr,
    input  logic [BANK_COUNT*ACC_WIDTH-1:0]               acc_data,
    input  logic                                          swap_req,
    output logic                                          swap_ack,
    output logic                                          drain_valid,
    input  logic                                          drain_ready,
    output logic [ACC_WIDTH-1:0]                          drain_data,
    output logic [(BANK_COUNT > 1 ? $clog2(BANK_COUNT) : 1)-1:0] drain_bank,
    output logic [$clog2(DEPTH)-1:0]                      drain_addr,
    output logic                                          drain_last,
    output logic                                          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = BANK_COUNT > 1 ? $clog2(BANK_COUNT) : 1;
    localparam int H  = ACC_WIDTH / 2;
    localparam int Q  = ACC_WIDTH / 4;

    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic lane_lsb(input int i, input logic [1:0] m);
        return i == 0 || (m == 2'b01 && i % H == 0) || (m == 2'b10 && i % Q == 0);
    endfunction

    // Ripple add with the carry killed at every lane boundary.
    function automatic logic [ACC_WIDTH-1:0] lane_add(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b,
                                                      input logic [1:0] m);
        logic [ACC_WIDTH-1:0] r;
        logic c;
`ifdef ACC_SATURATE_EN
        int s;
        s = 0;
`endif
        r = '0;
        c = 1'b0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (lane_lsb(i, m)) c = 1'b0;
            r[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
`ifdef ACC_SATURATE_EN
            if (lane_lsb(i, m)) s = i;
            if ((i == ACC_WIDTH - 1 || lane_lsb(i + 1, m)) && a[i] == b[i] && r[i] != a[i])
                for (int j = 0; j < ACC_WIDTH; j++)
                    if (j >= s && j <= i) r[j] = (j == i) ? a[i] : ~a[i];
`endif
        end
        return r;
    endfunction

    logic [ACC_WIDTH-1:0] r_mem [2][BANK_COUNT][DEPTH];
    logic                 r_front;
    logic [1:0]           r_mode;
    state_t               r_state, w_next;
    logic [BANK_COUNT-1:0] r_s1_v, r_s2_v;
    logic [AW-1:0]        r_s1_addr [BANK_COUNT];
    logic [AW-1:0]        r_s2_addr [BANK_COUNT];
    logic [ACC_WIDTH-1:0] r_s1_data [BANK_COUNT];
    logic [ACC_WIDTH-1:0] r_s2_data [BANK_COUNT];
    logic [ACC_WIDTH-1:0] r_s2_old  [BANK_COUNT];
    logic [ACC_WIDTH-1:0] w_sum     [BANK_COUNT];
    logic [ACC_WIDTH-1:0] w_old     [BANK_COUNT];
    logic [BW-1:0]        r_dbank;
    logic [AW-1:0]        r_daddr;
    logic                 w_swap, w_hs, w_end;

    assign w_end  = r_dbank == BW'(BANK_COUNT - 1) && r_daddr == AW'(DEPTH - 1);
    assign w_hs   = r_state == DRAIN && drain_ready;
    assign w_swap = !reset && swap_req && r_state == IDLE && !(|r_s1_v) && !(|r_s2_v) && !(|acc_valid);

    // S1 reads the front entry, taking the in-flight S2 result when addresses collide.
    always_comb begin
        for (int b = 0; b < BANK_COUNT; b++) begin
            w_sum[b] = lane_add(r_s2_old[b], r_s2_data[b], r_mode);
            w_old[b] = (r_s2_v[b] && r_s2_addr[b] == r_s1_addr[b]) ? w_sum[b] : r_mem[r_front][b][r_s1_addr[b]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_front <= 1'b0;
            r_mode  <= 2'b00;
            r_s1_v  <= '0;
            r_s2_v  <= '0;
            r_dbank <= '0;
            r_daddr <= '0;
            for (int f = 0; f < 2; f++)
                for (int b = 0; b < BANK_COUNT; b++)
                    for (int a = 0; a < DEPTH; a++)
                        r_mem[f][b][a] <= '0;
        end else begin
            r_s1_v <= acc_valid;
            r_s2_v <= r_s1_v;
            for (int b = 0; b < BANK_COUNT; b++) begin
                r_s1_addr[b] <= acc_addr[b*AW +: AW];
                r_s1_data[b] <= acc_data[b*ACC_WIDTH +: ACC_WIDTH];
                r_s2_addr[b] <= r_s1_addr[b];
                r_s2_data[b] <= r_s1_data[b];
                r_s2_old[b]  <= w_old[b];
                if (r_s2_v[b]) r_mem[r_front][b][r_s2_addr[b]] <= w_sum[b];
            end
            if (w_swap) begin
                r_front <= ~r_front;
                r_mode  <= mode;
                r_dbank <= '0;
                r_daddr <= '0;
            end
            if (w_hs) begin
                r_mem[~r_front][r_dbank][r_daddr] <= '0;
                r_daddr <= r_daddr + 1'b1;
                r_dbank <= w_end ? '0 : r_dbank + BW'(r_daddr == AW'(DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_swap ? DRAIN : IDLE) : ((w_hs && w_end) ? IDLE : DRAIN);
    end

    always_comb begin
        swap_ack    = w_swap;
        drain_valid = r_state == DRAIN;
        drain_data  = drain_valid ? r_mem[~r_front][r_dbank][r_daddr] : '0;
        drain_bank  = r_dbank;
        drain_addr  = r_daddr;
        drain_last  = drain_valid && w_end;
        busy        = drain_valid || (|r_s1_v) || (|r_s2_v);
    end
endmodule
